phy_tx_scheduler: RTL and testbench

//  Transmit-side link controller and arbiter for the two-lane PCIe PHY datapath.
//  - Sequences link bring-up: holds the lanes idle, then sends COM training symbols for a fixed time.
//  - Once active, shares the two PHY lanes among four source FIFOs using round-robin arbitration.
//  - Drives data_in_0/1 and valid_data_in_0/1 of the phy directly.

---
 rtl/phy_tx_scheduler.sv | 151 +++++++++++++++
 tb/tb_phy_tx_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_scheduler.sv
// rtl/phy_tx_scheduler.sv - two-lane PHY transmit link sequencer and round-robin source arbiter
// Brings the link up (RESET -> INIT -> ACTIVE), then grants up to two of four FIFOs per cycle.
module phy_tx_scheduler #(
    parameter int                 DATA_W      = 8,
    parameter int                 INIT_CYCLES = 16,
    parameter logic [DATA_W-1:0]  COM_SYMBOL  = DATA_W'('hBC)
) (
    input  logic              clk_8f,
    input  logic              reset_L,
    input  logic              enable,
    input  logic              pause,
    input  logic [3:0]        fifo_empty,
    input  logic [DATA_W-1:0] fifo_data_0,
    input  logic [DATA_W-1:0] fifo_data_1,
    input  logic [DATA_W-1:0] fifo_data_2,
    input  logic [DATA_W-1:0] fifo_data_3,
    output logic [3:0]        fifo_pop,
    output logic [DATA_W-1:0] data_out_0,
    output logic              valid_out_0,
    output logic [DATA_W-1:0] data_out_1,
    output logic              valid_out_1,
    output logic [1:0]        link_state
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam int               CNT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  init_cnt_q, init_cnt_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] data_0_q, data_0_d;
    logic [DATA_W-1:0] data_1_q, data_1_d;
    logic              valid_0_q, valid_0_d;
    logic              valid_1_q, valid_1_d;

    logic [DATA_W-1:0] head [4];
    logic              arb_en;
    logic              g0_vld, g1_vld;
    logic [1:0]        g0_idx, g1_idx;

    assign head[0] = fifo_data_0;
    assign head[1] = fifo_data_1;
    assign head[2] = fifo_data_2;
    assign head[3] = fifo_data_3;

    // Scan from rr_ptr upward; first hit feeds lane 0, second feeds lane 1.
    always_comb begin
        arb_en = enable && (state_q == ST_ACTIVE) && !pause;
        g0_vld = 1'b0;
        g0_idx = 2'd0;
        g1_vld = 1'b0;
        g1_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (arb_en && !fifo_empty[rr_ptr_q + 2'(k)]) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0_idx = rr_ptr_q + 2'(k);
                end else if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = rr_ptr_q + 2'(k);
                end
            end
        end
    end

    always_comb begin
        fifo_pop = 4'b0000;
        if (g0_vld) fifo_pop[g0_idx] = 1'b1;
        if (g1_vld) fifo_pop[g1_idx] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        data_0_d   = COM_SYMBOL;
        data_1_d   = COM_SYMBOL;
        valid_0_d  = 1'b0;
        valid_1_d  = 1'b0;
        if (!enable) begin
            state_d    = ST_RESET;
            init_cnt_d = '0;
            data_0_d   = '0;
            data_1_d   = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                end
                ST_INIT: begin
                    if (init_cnt_q == CNT_LAST) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        init_cnt_d = init_cnt_q + 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (g0_vld) begin
                        data_0_d  = head[g0_idx];
                        valid_0_d = 1'b1;
                        rr_ptr_d  = g0_idx + 2'd1;
                    end
                    if (g1_vld) begin
                        data_1_d  = head[g1_idx];
                        valid_1_d = 1'b1;
                        rr_ptr_d  = g1_idx + 2'd1;
                    end
                end
                default: begin
                    state_d  = ST_RESET;
                    data_0_d = '0;
                    data_1_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= ST_RESET;
            init_cnt_q <= '0;
            rr_ptr_q   <= 2'd0;
            data_0_q   <= '0;
            data_1_q   <= '0;
            valid_0_q  <= 1'b0;
            valid_1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            data_0_q   <= data_0_d;
            data_1_q   <= data_1_d;
            valid_0_q  <= valid_0_d;
            valid_1_q  <= valid_1_d;
        end
    end

    assign data_out_0  = data_0_q;
    assign data_out_1  = data_1_q;
    assign valid_out_0 = valid_0_q;
    assign valid_out_1 = valid_1_q;
    assign link_state  = state_q;

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// tb/tb_phy_tx_scheduler.sv - scoreboard bench for phy_tx_scheduler against a queue-based link model
module tb_phy_tx_scheduler;

    localparam int         IC  = 16;
    localparam logic [7:0] COM = 8'hBC;

    logic       clk_8f = 1'b0;
    logic       reset_L;
    logic       enable;
    logic       pause;
    logic [3:0] fifo_empty;
    logic [7:0] fdat [4];
    logic [3:0] fifo_pop;
    logic [7:0] data_out_0, data_out_1;
    logic       valid_out_0, valid_out_1;
    logic [1:0] link_state;

    int checks = 0;
    int errors = 0;

    logic [7:0]  fq [4][$];
    logic [19:0] exp_q [$];

    int m_state = 0;
    int m_init  = 0;
    int m_rr    = 0;

    always #5 clk_8f = ~clk_8f;

    phy_tx_scheduler #(.DATA_W(8), .INIT_CYCLES(IC), .COM_SYMBOL(COM)) dut (
        .clk_8f      (clk_8f),
        .reset_L     (reset_L),
        .enable      (enable),
        .pause       (pause),
        .fifo_empty  (fifo_empty),
        .fifo_data_0 (fdat[0]),
        .fifo_data_1 (fdat[1]),
        .fifo_data_2 (fdat[2]),
        .fifo_data_3 (fdat[3]),
        .fifo_pop    (fifo_pop),
        .data_out_0  (data_out_0),
        .valid_out_0 (valid_out_0),
        .data_out_1  (data_out_1),
        .valid_out_1 (valid_out_1),
        .link_state  (link_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive_fifos();
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i] = (fq[i].size() == 0);
            fdat[i]       = (fq[i].size() != 0) ? fq[i][0] : 8'($urandom);
        end
    endtask

    // Model: sources listed in round-robin order starting at m_rr, first two non-empty win.
    task automatic step(input logic en, input logic pa);
        int         gl [$];
        int         ns;
        logic [3:0] exp_pop;
        logic [7:0] d0, d1;
        logic       v0, v1;
        @(negedge clk_8f);
        enable = en;
        pause  = pa;
        drive_fifos();
        #1;
        exp_pop = 4'b0;
        d0 = COM; d1 = COM; v0 = 1'b0; v1 = 1'b0;
        ns = m_state;
        if (!en) begin
            ns = 0; d0 = 8'h00; d1 = 8'h00;
        end else if (m_state == 0) begin
            ns = 1; m_init = 0;
        end else if (m_state == 1) begin
            m_init++;
            if (m_init == IC) ns = 2;
        end else begin
            if (!pa) begin
                for (int k = 0; k < 4; k++) begin
                    int s;
                    s = (m_rr + k) % 4;
                    if (fq[s].size() > 0 && gl.size() < 2) gl.push_back(s);
                end
            end
            if (gl.size() > 0) begin d0 = fq[gl[0]][0]; v0 = 1'b1; end
            if (gl.size() > 1) begin d1 = fq[gl[1]][0]; v1 = 1'b1; end
        end
        foreach (gl[j]) exp_pop[gl[j]] = 1'b1;
        check("fifo_pop", {28'b0, fifo_pop}, {28'b0, exp_pop});
        exp_q.push_back({2'(ns), v0, d0, v1, d1});
        foreach (gl[j]) void'(fq[gl[j]].pop_front());
        if (gl.size() > 0) m_rr = (gl[gl.size()-1] + 1) % 4;
        m_state = ns;
    endtask

    always @(posedge clk_8f) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [19:0] e;
            e = exp_q.pop_front();
            check("lanes", {12'b0, link_state, valid_out_0, data_out_0, valid_out_1, data_out_1},
                  {12'b0, e});
        end
    end

    initial begin
        reset_L = 1'b0;
        enable  = 1'b0;
        pause   = 1'b0;
        drive_fifos();
        #2;
        check("reset_outs", {12'b0, link_state, valid_out_0, data_out_0, valid_out_1, data_out_1}, 32'h0);
        check("reset_pop", {28'b0, fifo_pop}, 32'h0);
        #1 reset_L = 1'b1;

        // bring-up: 1 edge into INIT, IC edges of COM, then ACTIVE
        repeat (IC + 1) step(1'b1, 1'b0);

        // four heads with rr at 0
        fq[0].push_back(8'h10); fq[1].push_back(8'h20);
        fq[2].push_back(8'h30); fq[3].push_back(8'h40);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        // single source 2, then rr must start at 3
        fq[2].push_back(8'hA5);
        step(1'b1, 1'b0);
        fq[0].push_back(8'h01); fq[3].push_back(8'h33);
        step(1'b1, 1'b0);

        // pause with data waiting
        for (int i = 0; i < 4; i++) begin fq[i].push_back(8'(8'h50 + i)); fq[i].push_back(8'(8'h60 + i)); end
        repeat (3) step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b0);

        // enable drop mid-burst, then full restart
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        repeat (IC + 1) step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) fq[i].push_back(8'(8'h70 + i));
        step(1'b1, 1'b0);

        // async reset between edges while ACTIVE with words in flight
        for (int i = 0; i < 4; i++) fq[i].push_back(8'(8'h80 + i));
        step(1'b1, 1'b0);
        @(posedge clk_8f);
        #3;
        reset_L = 1'b0;
        enable  = 1'b0;
        #1;
        check("async_outs", {12'b0, link_state, valid_out_0, data_out_0, valid_out_1, data_out_1}, 32'h0);
        check("async_pop", {28'b0, fifo_pop}, 32'h0);
        m_state = 0; m_init = 0; m_rr = 0;
        @(negedge clk_8f);
        reset_L = 1'b1;
        repeat (IC + 1) step(1'b1, 1'b0);

        // randomized traffic
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(2) == 0 && fq[i].size() < 4) fq[i].push_back(8'($urandom));
            step(($urandom_range(49) != 0), ($urandom_range(4) == 0));
        end

        repeat (2) @(posedge clk_8f);
        #3;
        check("drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
